// File: rtl/tdm_demux_1to2.sv
// Serial TDM demultiplexer: splits an interleaved two-channel bit stream into
// per-channel words with valid/ready handoff and sticky overflow flags.
module tdm_demux_1to2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_en,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic             ch0_valid,
  input  logic             ch0_ready,
  output logic [WIDTH-1:0] ch1_data,
  output logic             ch1_valid,
  input  logic             ch1_ready,
  output logic             ovf0,
  output logic             ovf1,
  input  logic             ovf_clr,
  output logic             frame_err
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(2 * WIDTH - 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic             load_q, load_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] ch0_data_q, ch0_data_d;
  logic [WIDTH-1:0] ch1_data_q, ch1_data_d;
  logic             ch0_valid_q, ch0_valid_d;
  logic             ch1_valid_q, ch1_valid_d;
  logic             ovf0_q, ovf0_d;
  logic             ovf1_q, ovf1_d;

  // A sync-marked bit always restarts the frame, whatever state we were in.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    if (din_en) begin
      if (sync) begin
        frame_err_d = (state_q == RECV);
        sh0_d       = {{(WIDTH-1){1'b0}}, din};
        sh1_d       = '0;
        cnt_d       = CW'(1);
        state_d     = RECV;
      end else if (state_q == RECV) begin
        if (!cnt_q[0]) begin
          sh0_d = {sh0_q[WIDTH-2:0], din};
        end else begin
          sh1_d = {sh1_q[WIDTH-2:0], din};
        end
        if (cnt_q == LAST_BIT) begin
          load_d  = 1'b1;
          cnt_d   = '0;
          state_d = HUNT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Loading while the old word is still pending (and not leaving) is an overflow.
  always_comb begin
    ch0_data_d  = ch0_data_q;
    ch0_valid_d = ch0_valid_q;
    ovf0_d      = ovf_clr ? 1'b0 : ovf0_q;
    if (load_q) begin
      ch0_data_d  = sh0_q;
      ch0_valid_d = 1'b1;
      if (ch0_valid_q && !ch0_ready) begin
        ovf0_d = 1'b1;
      end
    end else if (ch0_valid_q && ch0_ready) begin
      ch0_valid_d = 1'b0;
    end
  end

  always_comb begin
    ch1_data_d  = ch1_data_q;
    ch1_valid_d = ch1_valid_q;
    ovf1_d      = ovf_clr ? 1'b0 : ovf1_q;
    if (load_q) begin
      ch1_data_d  = sh1_q;
      ch1_valid_d = 1'b1;
      if (ch1_valid_q && !ch1_ready) begin
        ovf1_d = 1'b1;
      end
    end else if (ch1_valid_q && ch1_ready) begin
      ch1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      ch0_data_q  <= '0;
      ch1_data_q  <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      ovf0_q      <= 1'b0;
      ovf1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      ch0_data_q  <= ch0_data_d;
      ch1_data_q  <= ch1_data_d;
      ch0_valid_q <= ch0_valid_d;
      ch1_valid_q <= ch1_valid_d;
      ovf0_q      <= ovf0_d;
      ovf1_q      <= ovf1_d;
    end
  end

  assign ch0_data  = ch0_data_q;
  assign ch1_data  = ch1_data_q;
  assign ch0_valid = ch0_valid_q;
  assign ch1_valid = ch1_valid_q;
  assign ovf0      = ovf0_q;
  assign ovf1      = ovf1_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Directed self-checking bench for tdm_demux_1to2 at WIDTH=8: clean frames,
// gapped input, overflow/clear, misplaced sync, mid-frame reset and hunt discard.
module tb_tdm_demux_1to2;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_en;
  logic       sync;
  logic [7:0] ch0_data;
  logic       ch0_valid;
  logic       ch0_ready;
  logic [7:0] ch1_data;
  logic       ch1_valid;
  logic       ch1_ready;
  logic       ovf0;
  logic       ovf1;
  logic       ovf_clr;
  logic       frame_err;

  int assertCount = 0;
  int failCount   = 0;

  tdm_demux_1to2 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_en    (din_en),
    .sync      (sync),
    .ch0_data  (ch0_data),
    .ch0_valid (ch0_valid),
    .ch0_ready (ch0_ready),
    .ch1_data  (ch1_data),
    .ch1_valid (ch1_valid),
    .ch1_ready (ch1_ready),
    .ovf0      (ovf0),
    .ovf1      (ovf1),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic en, input logic s, input logic d);
    din_en = en;
    sync   = s;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic frameBit(input logic [7:0] c0, input logic [7:0] c1, input int i);
    return (i % 2 == 0) ? c0[7 - i/2] : c1[7 - i/2];
  endfunction

  task automatic sendFrame(input logic [7:0] c0, input logic [7:0] c1,
                           input logic gap, input logic expErr);
    for (int i = 0; i < 16; i++) begin
      if (gap) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, i == 0, frameBit(c0, c1, i));
      if (i == 0) checkOutput("frame_err_at_sync", 32'(frame_err), 32'(expErr));
      if (i == 1) checkOutput("frame_err_one_cycle", 32'(frame_err), 0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ch0_data"}, 32'(ch0_data), 0);
    checkOutput({tag, "_ch1_data"}, 32'(ch1_data), 0);
    checkOutput({tag, "_ch0_valid"}, 32'(ch0_valid), 0);
    checkOutput({tag, "_ch1_valid"}, 32'(ch1_valid), 0);
    checkOutput({tag, "_ovf0"}, 32'(ovf0), 0);
    checkOutput({tag, "_ovf1"}, 32'(ovf1), 0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  task automatic checkWords(input string tag, input logic [7:0] c0, input logic [7:0] c1);
    checkOutput({tag, "_ch0_valid"}, 32'(ch0_valid), 1);
    checkOutput({tag, "_ch1_valid"}, 32'(ch1_valid), 1);
    checkOutput({tag, "_ch0_data"}, 32'(ch0_data), 32'(c0));
    checkOutput({tag, "_ch1_data"}, 32'(ch1_data), 32'(c1));
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 1'b0;
    din_en    = 1'b0;
    sync      = 1'b0;
    ch0_ready = 1'b1;
    ch1_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    #2 rst_n = 1'b1;

    // Clean frame, both consumers ready.
    sendFrame(8'hA5, 8'h3C, 1'b0, 1'b0);
    checkOutput("basic_no_early_valid0", 32'(ch0_valid), 0);
    checkOutput("basic_no_early_valid1", 32'(ch1_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("basic", 8'hA5, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_valid0_drop", 32'(ch0_valid), 0);
    checkOutput("basic_valid1_drop", 32'(ch1_valid), 0);

    // Same frame with din_en toggling.
    sendFrame(8'hA5, 8'h3C, 1'b1, 1'b0);
    checkOutput("gap_no_early_valid0", 32'(ch0_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("gap", 8'hA5, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap_valid0_drop", 32'(ch0_valid), 0);

    // Channel 0 stalls: second frame overflows it.
    ch0_ready = 1'b0;
    sendFrame(8'hA5, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("stall1", 8'hA5, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall_ch1_taken", 32'(ch1_valid), 0);
    checkOutput("stall_ch0_held", 32'(ch0_valid), 1);
    sendFrame(8'h11, 8'h22, 1'b0, 1'b0);
    checkOutput("stall_ch0_stable", 32'(ch0_data), 'hA5);
    checkOutput("stall_no_ovf_yet", 32'(ovf0), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("ovf", 8'h11, 8'h22);
    checkOutput("ovf_ovf0_set", 32'(ovf0), 1);
    checkOutput("ovf_ovf1_clear", 32'(ovf1), 0);
    ovf_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("ovf_clr_ovf0", 32'(ovf0), 0);

    // Load coinciding with a transfer is not an overflow.
    sendFrame(8'h33, 8'h44, 1'b0, 1'b0);
    ch0_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("xfer_load", 8'h33, 8'h44);
    checkOutput("xfer_load_no_ovf", 32'(ovf0), 0);
    ch0_ready = 1'b0;

    // Overflow on the same edge as ovf_clr leaves the flag set.
    sendFrame(8'h55, 8'h66, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("ovf_beats_clr", 32'(ovf0), 1);
    checkOutput("ovf_beats_clr_data", 32'(ch0_data), 'h55);
    ovf_clr   = 1'b1;
    ch0_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("final_clr_ovf0", 32'(ovf0), 0);
    checkOutput("final_ch0_taken", 32'(ch0_valid), 0);

    // Sync reasserted at frame bit 6.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, i == 0, frameBit(8'hA5, 8'h3C, i));
      checkOutput("partial_no_err", 32'(frame_err), 0);
    end
    sendFrame(8'h5A, 8'hC3, 1'b0, 1'b1);
    checkOutput("abort_no_valid", 32'(ch0_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("after_abort", 8'h5A, 8'hC3);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset at frame bit 9.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, i == 0, frameBit(8'hFF, 8'hFF, i));
    din_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    checkAllZero("midreset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkAllZero("post_reset_hunt");
    sendFrame(8'h96, 8'h69, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkWords("post_reset", 8'h96, 8'h69);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Unsynced bits in HUNT are silently dropped.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      checkOutput("hunt_no_err", 32'(frame_err), 0);
      checkOutput("hunt_no_valid", 32'(ch0_valid | ch1_valid), 0);
    end
    checkOutput("hunt_ch0_unchanged", 32'(ch0_data), 'h96);
    checkOutput("hunt_ch1_unchanged", 32'(ch1_data), 'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
